// File: rtl/period_wave_gen_if.sv
// Period-word / waveform bundle between the period PIOs and period_wave_gen.
interface period_wave_gen_if #(
    parameter int W   = 28,
    parameter int NCH = 4
);
    logic [W-1:0]   period1;
    logic [W-1:0]   period2;
    logic [W-1:0]   period3;
    logic [W-1:0]   period4;
    logic           restart;
    logic [NCH-1:0] wave;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] active;

    modport master (
        output period1, period2, period3, period4, restart,
        input  wave, tick, active
    );

    modport slave (
        input  period1, period2, period3, period4, restart,
        output wave, tick, active
    );
endinterface

// File: rtl/period_wave_gen.sv
// Four-channel square-wave generator; period words take effect only at
// period boundaries (or on restart), so PIO rewrites never produce runt pulses.
//
//   state    | meaning
//   ST_IDLE  | p_act = 0, outputs 0, period input sampled every cycle
//   ST_RUN   | cnt counts 0..p_act-1, period input sampled only at boundary
module period_wave_gen #(
    parameter int NCH = 4,
    parameter int W   = 28
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    period_wave_gen_if.slave pw
);
    localparam logic [0:0]   ST_IDLE = 1'b0;
    localparam logic [0:0]   ST_RUN  = 1'b1;
    localparam logic [W-1:0] P_MIN   = W'(2);
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0]   per_in   [NCH];
    logic [0:0]     state_q  [NCH];
    logic [0:0]     state_d  [NCH];
    logic [W-1:0]   p_act_q  [NCH];
    logic [W-1:0]   p_act_d  [NCH];
    logic [W-1:0]   cnt_q    [NCH];
    logic [W-1:0]   cnt_d    [NCH];
    logic [NCH-1:0] wave_q,   wave_d;
    logic [NCH-1:0] tick_q,   tick_d;
    logic [NCH-1:0] active_q, active_d;

    assign per_in[0] = pw.period1;
    assign per_in[1] = pw.period2;
    assign per_in[2] = pw.period3;
    assign per_in[3] = pw.period4;

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            state_d[n] = state_q[n];
            p_act_d[n] = p_act_q[n];
            cnt_d[n]   = cnt_q[n];
            // restart, idle polling and period boundary all resample the input
            if (pw.restart || (state_q[n] == ST_IDLE) || (cnt_q[n] == p_act_q[n] - ONE)) begin
                cnt_d[n] = '0;
                if (per_in[n] >= P_MIN) begin
                    state_d[n] = ST_RUN;
                    p_act_d[n] = per_in[n];
                end else begin
                    state_d[n] = ST_IDLE;
                    p_act_d[n] = '0;
                end
            end else begin
                cnt_d[n] = cnt_q[n] + ONE;
            end
            // outputs registered from next-state so they line up with cnt_q/p_act_q
            active_d[n] = (state_d[n] == ST_RUN);
            wave_d[n]   = active_d[n] && (cnt_d[n] < (p_act_d[n] >> 1));
            tick_d[n]   = active_d[n] && (cnt_d[n] == '0);
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int n = 0; n < NCH; n++) begin
                state_q[n] <= ST_IDLE;
                p_act_q[n] <= '0;
                cnt_q[n]   <= '0;
            end
            wave_q   <= '0;
            tick_q   <= '0;
            active_q <= '0;
        end else begin
            for (int n = 0; n < NCH; n++) begin
                state_q[n] <= state_d[n];
                p_act_q[n] <= p_act_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
            wave_q   <= wave_d;
            tick_q   <= tick_d;
            active_q <= active_d;
        end
    end

    assign pw.wave   = wave_q;
    assign pw.tick   = tick_q;
    assign pw.active = active_q;
endmodule

// File: tb/tb_period_wave_gen.sv
// Bench for period_wave_gen: cycle scoreboard against a behavioural channel
// model, plus directed checks and a shortened (W=8) maximum-period instance.
module tb_period_wave_gen;
    logic clk_clk;
    logic rst;

    period_wave_gen_if #(.W(28), .NCH(4)) bus ();
    period_wave_gen_if #(.W(8),  .NCH(4)) sm ();

    period_wave_gen #(.NCH(4), .W(28)) u_dut (
        .clk_clk     (clk_clk),
        .reset_reset (rst),
        .pw          (bus)
    );

    period_wave_gen #(.NCH(4), .W(8)) u_small (
        .clk_clk     (clk_clk),
        .reset_reset (rst),
        .pw          (sm)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int n_chk;
    int n_err;
    logic [11:0] exp_q [$];
    int m_per [4];
    int m_pos [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int per_of(input int n);
        case (n)
            0: per_of = int'(bus.period1);
            1: per_of = int'(bus.period2);
            2: per_of = int'(bus.period3);
            default: per_of = int'(bus.period4);
        endcase
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_per[n] = 0;
            m_pos[n] = 0;
        end
    endtask

    // Advance the model one clock, push expected outputs, clock the DUT, compare.
    task automatic step();
        logic [3:0] w, t, a;
        logic [11:0] e;
        for (int n = 0; n < 4; n++) begin
            int p;
            p = per_of(n);
            if (bus.restart || m_per[n] == 0 || m_pos[n] == m_per[n] - 1) begin
                m_pos[n] = 0;
                m_per[n] = (p >= 2) ? p : 0;
            end else begin
                m_pos[n]++;
            end
            a[n] = (m_per[n] >= 2);
            w[n] = a[n] && (m_pos[n] < m_per[n] / 2);
            t[n] = a[n] && (m_pos[n] == 0);
        end
        exp_q.push_back({w, t, a});
        @(posedge clk_clk);
        #1;
        e = exp_q.pop_front();
        chk("cyc", {20'd0, bus.wave, bus.tick, bus.active}, {20'd0, e});
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        int cnt;
        int hi;
        int lo;
        logic [3:0] pat;
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        bus.period1 = '0; bus.period2 = '0; bus.period3 = '0; bus.period4 = '0;
        bus.restart = 1'b0;
        sm.period1 = '0; sm.period2 = '0; sm.period3 = '0; sm.period4 = '0;
        sm.restart = 1'b0;
        model_reset();
        @(posedge clk_clk); #1;
        bus.period1 = 28'd4;
        @(posedge clk_clk); #1;
        chk("rst_out", {20'd0, bus.wave, bus.tick, bus.active}, 32'd0);
        rst = 1'b0;

        // basic waves: P=4 and P=5 from idle, P=1 stays idle
        bus.period2 = 28'd5;
        bus.period3 = 28'd1;
        step();
        chk("start_ch0", {29'd0, bus.active[0], bus.tick[0], bus.wave[0]}, 32'd7);
        steps(20);
        chk("p1_idle", {31'd0, bus.active[2]}, 32'd0);

        // glitch-free rewrite 4 -> 6 while cnt==1
        cnt = 0;
        while (m_pos[0] != 1 && cnt < 10) begin step(); cnt++; end
        chk("wait_cnt1", {31'd0, m_pos[0] == 1}, 32'd1);
        bus.period1 = 28'd6;
        cnt = 0;
        for (int i = 0; i < 2; i++) begin step(); cnt += int'(bus.tick[0]); end
        chk("no_early_tick", cnt, 0);
        step();
        chk("new_tick", {31'd0, bus.tick[0]}, 32'd1);
        steps(12);

        // period4=8 running, dropped to 0 at cnt==2: old period completes
        bus.period4 = 28'd8;
        cnt = 0;
        while (m_pos[3] != 2 && cnt < 20) begin step(); cnt++; end
        chk("wait_p4_cnt2", {31'd0, m_pos[3] == 2}, 32'd1);
        bus.period4 = 28'd0;
        cnt = 0;
        while (bus.active[3] && cnt < 20) begin step(); cnt++; end
        chk("p4_drain", cnt, 6);
        chk("p4_wave_off", {31'd0, bus.wave[3]}, 32'd0);

        // restart alignment with arbitrary phases
        bus.period1 = 28'd4; bus.period2 = 28'd5; bus.period3 = 28'd6; bus.period4 = 28'd7;
        steps(3 + $urandom_range(0, 9));
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        chk("rs_tick", {28'd0, bus.tick}, 32'hF);
        chk("rs_wave", {28'd0, bus.wave}, 32'hF);
        steps(7);

        // restart coinciding with a boundary and a period change
        cnt = 0;
        while (m_pos[0] != m_per[0] - 1 && cnt < 10) begin step(); cnt++; end
        bus.period1 = 28'd9;
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        chk("rsb_tick", {28'd0, bus.tick}, 32'hF);
        steps(20);

        // reset asserted between edges with period1=4 running
        bus.period2 = '0; bus.period3 = '0; bus.period4 = '0;
        bus.period1 = 28'd4;
        steps(10);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", {20'd0, bus.wave, bus.tick, bus.active}, 32'd0);
        model_reset();
        @(posedge clk_clk); #1;
        chk("rst_hold", {20'd0, bus.wave, bus.tick, bus.active}, 32'd0);
        rst = 1'b0;
        pat = 4'b1100;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("resume_wave", {31'd0, bus.wave[0]}, {31'd0, pat[3 - (i % 4)]});
            chk("resume_tick", {31'd0, bus.tick[0]}, {31'd0, (i % 4) == 0});
        end

        // maximum period on the 8-bit instance: high 127, low 128
        sm.period1 = 8'hFF;
        cnt = 0;
        while (!sm.tick[0] && cnt < 600) begin step(); cnt++; end
        chk("max_start", {31'd0, sm.tick[0]}, 32'd1);
        hi = 0;
        while (sm.wave[0] && hi < 1000) begin hi++; step(); end
        lo = 0;
        while (!sm.wave[0] && lo < 1000) begin lo++; step(); end
        chk("max_high", hi, 127);
        chk("max_low", lo, 128);
        chk("max_wrap_tick", {31'd0, sm.tick[0]}, 32'd1);
        chk("max_active", {31'd0, sm.active[0]}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/period_wave_gen.md
# period_wave_gen

Four-channel square-wave generator directly downstream of the Nios II system's period PIOs. Each channel consumes one 28-bit period word (period1..period4, in clk_clk cycles) and produces a continuous square wave plus a one-cycle period-start tick. Period changes are applied glitch-free at period boundaries, so software may rewrite a PIO at any time.

## Interface
Parameters:
- NCH, 4, number of channels; fixed at 4 in this design.
- W, 28, period word width; matches the PIO width.

Ports:
- clk_clk  input  1  system clock, same domain as the PIOs.
- reset_reset  input  1  reset, asynchronous and active-high.
- period1..period4  input  W each  requested period in cycles for channels 0..3. Values 0 and 1 mean idle.
- restart  input  1  single-cycle synchronous pulse; realigns all channels.
- wave  output  NCH  square wave, bit n for channel n.
- tick  output  NCH  one-cycle pulse in the first cycle of each period.
- active  output  NCH  channel is running (P_act >= 2).

## Operation
- Per-channel state:
  - P_act (W bits): period currently in force.
  - cnt (W bits): position within the period, 0..P_act-1.
- Outputs are registers, derived from next-state, so they always match the current cnt and P_act:
  - active = (P_act >= 2)
  - wave = active && (cnt < (P_act >> 1))
  - tick = active && (cnt == 0)
- High time is floor(P/2) cycles; low time is the remainder. Examples:
  - P=4: high 2, low 2.
  - P=5: high 2, low 3.
  - P=2^28-1: high 2^27-1, low 2^27.
- Per-channel FSM:
  - IDLE (P_act=0): each cycle, sample the period input. If the value is >= 2, load P_act, set cnt=0, go to RUN. Otherwise stay in IDLE with all outputs 0.
  - RUN, cnt < P_act-1: cnt increments. The period input is ignored.
  - RUN, cnt == P_act-1 (boundary): sample the period input.
    - Value >= 2: load it into P_act, set cnt=0, stay in RUN. This applies to the same value or a new one.
    - Value < 2: clear P_act and cnt, go to IDLE.
- restart pulse: every channel samples its period input immediately, regardless of cnt. Values >= 2 give RUN with cnt=0; values < 2 give IDLE. Running channels are aligned so their ticks coincide on the next cycle.
- restart and a boundary in the same cycle: restart wins. The result is identical anyway because the input is sampled in both cases.
- The period input is treated as stable, same-clock data; no synchronizer. Arithmetic is unsigned W-bit. cnt never exceeds P_act-1, so no wrap-around is possible.

## Timing
- Reset: while reset_reset is high, every P_act, cnt, wave, tick and active is 0. Outputs clear asynchronously on assertion. The first state change happens on the first clk_clk edge after deassertion.
- Start-up latency: period n becomes >= 2 before edge k while the channel is idle. After edge k: active=1, tick=1, wave=1, cnt=0.
- Rewrite latency while running: a new value takes effect on the edge that follows the cycle where cnt == P_act-1. The old period always finishes; there are no runt or stretched pulses.
- restart latency: one edge. Outputs reflect cnt=0 in the following cycle.
- Reset asserted mid-period: outputs drop immediately. After release, each channel restarts from IDLE using the current inputs.
- Channels are fully independent except for the shared restart.

## Test plan
- Reset mid-run:
  - Stimulus: period1=4 running, assert reset_reset between edges.
  - Response: wave/tick/active go to 0 without waiting for an edge.
  - After release: wave[0] resumes 1,1,0,0 with tick[0] on the first cycle.
- Basic waves:
  - Stimulus: period1=4, period2=5 from idle.
  - Response: wave[0] repeats 1100, tick[0] every 4 cycles. wave[1] repeats 11000, tick[1] every 5 cycles.
- Glitch-free rewrite:
  - Stimulus: period1 changes 4 to 6 while cnt=1.
  - Response: 2 more old-period cycles (0,0), then tick and pattern 111000. No other tick in between.
- Idle values:
  - period3=1 from idle: active[2] stays 0.
  - period4=8 running, then set to 0 at cnt=2: the 8-cycle period completes, then active[3]=0 and wave[3]=0.
- restart alignment:
  - Stimulus: channels at P=4,5,6,7 in arbitrary phases; pulse restart.
  - Response: the next cycle has tick=4'b1111 and wave=4'b1111.
  - Also: restart on a boundary cycle with period1 changed behaves identically.
- Maximum period:
  - Stimulus: period1=28'hFFFFFFF (check a counter-forced/shortened variant in simulation).
  - Response: high for 2^27-1 cycles, low for 2^27. No overflow of cnt.
